// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Purpose  : Glyph table, anode codes and FSM states for the 7-segment bus.
// Revision : 1.0
// ============================================================================
package led_pkg;

    // Segment glyphs, active-high, bit 6 = a ... bit 0 = g
    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    // Decoder result {legal, nibble} for a pattern outside the table
    localparam logic [4:0] DEC_ILLEGAL = 5'b0_0000;

    // Anode codes {an3, an2, an1, an0}, one-cold
    localparam logic [3:0] AN_D0 = 4'b1110;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D3 = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/led_scan_decoder_seg7_to_hex.sv
`default_nettype none
// ============================================================================
// Module   : seg7_to_hex
// Purpose  : Combinational 7-segment glyph to hex nibble decoder.
// Revision : 1.0
// ============================================================================
module seg7_to_hex
    import led_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_legal
);

    always_comb begin
        {o_legal, o_nibble} = DEC_ILLEGAL;
        case (i_seg)
            GLYPH_0: {o_legal, o_nibble} = {1'b1, 4'h0};
            GLYPH_1: {o_legal, o_nibble} = {1'b1, 4'h1};
            GLYPH_2: {o_legal, o_nibble} = {1'b1, 4'h2};
            GLYPH_3: {o_legal, o_nibble} = {1'b1, 4'h3};
            GLYPH_4: {o_legal, o_nibble} = {1'b1, 4'h4};
            GLYPH_5: {o_legal, o_nibble} = {1'b1, 4'h5};
            GLYPH_6: {o_legal, o_nibble} = {1'b1, 4'h6};
            GLYPH_7: {o_legal, o_nibble} = {1'b1, 4'h7};
            GLYPH_8: {o_legal, o_nibble} = {1'b1, 4'h8};
            GLYPH_9: {o_legal, o_nibble} = {1'b1, 4'h9};
            GLYPH_A: {o_legal, o_nibble} = {1'b1, 4'hA};
            GLYPH_B: {o_legal, o_nibble} = {1'b1, 4'hB};
            GLYPH_C: {o_legal, o_nibble} = {1'b1, 4'hC};
            GLYPH_D: {o_legal, o_nibble} = {1'b1, 4'hD};
            GLYPH_E: {o_legal, o_nibble} = {1'b1, 4'hE};
            GLYPH_F: {o_legal, o_nibble} = {1'b1, 4'hF};
            default: {o_legal, o_nibble} = DEC_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/led_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_decoder
// Purpose  : Receive-side monitor rebuilding the 16-bit word from a 4-digit
//            multiplexed 7-segment bus.
// Revision : 1.0
// ============================================================================
module led_scan_decoder
    import led_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 4096,
    parameter int CW      = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        an3,
    input  logic        an2,
    input  logic        an1,
    input  logic        an0,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic        dp,
    output logic [15:0] word,
    output logic        valid,
    output logic        changed,
    output logic        seg_err,
    output logic        stale
);

    state_t          r_state;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp;
    logic [3:0]      r_prev_an;
    logic [6:0]      r_prev_seg;
    logic [3:0]      r_samp_an;
    logic [6:0]      r_samp_seg;
    logic [CW-1:0]   r_settle;
    logic [CW-1:0]   r_to;
    logic [3:0]      r_mask;
    logic [3:0][3:0] r_slot;

    logic            w_change;
    logic            w_single;
    logic [CW-1:0]   w_settle_next;
    logic [1:0]      w_idx;
    logic [3:0]      w_nib;
    logic            w_legal;
    logic            w_to_hit;
    logic [3:0]      w_mask_base;
    logic [3:0]      w_mask_set;
    logic [3:0][3:0] w_frame;
    logic            w_unused_dp;

    assign w_unused_dp = r_dp;

    assign w_change = {r_an, r_seg} != {r_prev_an, r_prev_seg};
    assign w_single = (r_an == AN_D0) || (r_an == AN_D1) ||
                      (r_an == AN_D2) || (r_an == AN_D3);

    always_comb begin
        w_settle_next = r_settle;
        if (!w_single || w_change) begin
            w_settle_next = '0;
        end else if (r_settle != CW'(SETTLE)) begin
            w_settle_next = r_settle + 1'b1;
        end
    end

    always_comb begin
        w_idx = 2'd0;
        case (r_samp_an)
            AN_D1:   w_idx = 2'd1;
            AN_D2:   w_idx = 2'd2;
            AN_D3:   w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    seg7_to_hex u_dec (
        .i_seg    (r_samp_seg),
        .o_nibble (w_nib),
        .o_legal  (w_legal)
    );

    // The timeout fires once, on the cycle the counter first reaches TIMEOUT
    assign w_to_hit    = (r_state != ST_EMIT) && (r_to == CW'(TIMEOUT - 1));
    assign w_mask_base = w_to_hit ? 4'b0000 : r_mask;
    assign w_mask_set  = w_mask_base | (4'b0001 << w_idx);

    always_comb begin
        w_frame        = r_slot;
        w_frame[w_idx] = w_nib;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_an       <= 4'hF;
            r_seg      <= 7'h00;
            r_dp       <= 1'b1;
            r_prev_an  <= 4'hF;
            r_prev_seg <= 7'h00;
            r_samp_an  <= 4'hF;
            r_samp_seg <= 7'h00;
            r_settle   <= '0;
            r_to       <= '0;
            r_mask     <= 4'b0000;
            r_slot     <= '0;
            word       <= 16'h0000;
            valid      <= 1'b0;
            changed    <= 1'b0;
            seg_err    <= 1'b0;
            stale      <= 1'b0;
        end else begin
            r_an       <= {an3, an2, an1, an0};
            r_seg      <= ~{a, b, c, d, e, f, g};
            r_dp       <= dp;
            r_prev_an  <= r_an;
            r_prev_seg <= r_seg;
            r_settle   <= w_settle_next;
            r_mask     <= w_mask_base;
            valid      <= 1'b0;
            changed    <= 1'b0;
            seg_err    <= 1'b0;

            if (r_state != ST_EMIT) begin
                if (r_to != CW'(TIMEOUT)) begin
                    r_to <= r_to + 1'b1;
                end
                if (w_to_hit) begin
                    stale <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    // Snapshot the settled pattern so a change during SAMPLE cannot corrupt it
                    if (w_single && (w_settle_next == CW'(SETTLE))) begin
                        r_samp_an  <= r_an;
                        r_samp_seg <= r_seg;
                        r_state    <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (w_legal) begin
                        r_slot[w_idx] <= w_nib;
                        r_mask        <= w_mask_set;
                    end else begin
                        seg_err <= 1'b1;
                    end
                    if (w_legal && (w_mask_set == 4'b1111)) begin
                        word    <= w_frame;
                        valid   <= 1'b1;
                        changed <= (w_frame != word);
                        r_mask  <= 4'b0000;
                        r_to    <= '0;
                        stale   <= 1'b0;
                        r_state <= ST_EMIT;
                    end else begin
                        r_state <= w_change ? ST_IDLE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_change) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    r_state <= w_change ? ST_IDLE : ST_HOLD;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_scan_decoder
// Purpose  : Directed self-checking bench for led_scan_decoder.
// Revision : 1.0
// ============================================================================
module tb_led_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        an3, an2, an1, an0;
    logic        a, b, c, d, e, f, g, dp;
    logic [15:0] word;
    logic        valid, changed, seg_err, stale;

    int          checks = 0;
    int          errors = 0;
    int          nvalid = 0;
    int          nerr   = 0;
    logic [15:0] last_word = 16'h0000;
    logic        last_changed = 1'b0;
    logic [6:0]  glyph [16];

    always #5 clk = ~clk;

    led_scan_decoder #(.SETTLE(4), .TIMEOUT(4096), .CW(13)) dut (
        .clk     (clk),
        .reset   (reset),
        .an3     (an3),
        .an2     (an2),
        .an1     (an1),
        .an0     (an0),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
        .g       (g),
        .dp      (dp),
        .word    (word),
        .valid   (valid),
        .changed (changed),
        .seg_err (seg_err),
        .stale   (stale)
    );

    always @(negedge clk) begin
        if (valid) begin
            nvalid++;
            last_word    = word;
            last_changed = changed;
        end
        if (seg_err) begin
            nerr++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_bus(input logic [3:0] an, input logic [6:0] seg);
        {an3, an2, an1, an0} = an;
        {a, b, c, d, e, f, g} = ~seg;
        dp = 1'b1;
    endtask

    task automatic send_digit(input int idx, input logic [3:0] nib);
        logic [3:0] an;
        an = ~(4'b0001 << idx);
        set_bus(an, glyph[nib]);
        tick(8);
        set_bus(4'hF, 7'h00);
        tick(2);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_digit(i, w[i*4 +: 4]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_bus(4'hF, 7'h00);
        tick(4);
        reset = 1'b0;
        tick(1);
        checks++; if (word !== 16'h0000) begin errors++; $display("FAIL reset_word got=%h exp=0000", word); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed got=%b exp=0", changed); end
        checks++; if (seg_err !== 1'b0) begin errors++; $display("FAIL reset_seg_err got=%b exp=0", seg_err); end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL reset_stale got=%b exp=0", stale); end
    endtask

    task automatic test_frame();
        int v0;
        v0 = nvalid;
        send_word(16'hA194);
        checks++; if (nvalid !== v0 + 1) begin errors++; $display("FAIL frame_count got=%0d exp=%0d", nvalid, v0 + 1); end
        checks++; if (last_word !== 16'hA194) begin errors++; $display("FAIL frame_word got=%h exp=a194", last_word); end
        checks++; if (last_changed !== 1'b1) begin errors++; $display("FAIL frame_changed got=%b exp=1", last_changed); end
    endtask

    task automatic test_back_to_back();
        send_word(16'hCC10);
        checks++; if (last_word !== 16'hCC10) begin errors++; $display("FAIL b2b_word got=%h exp=cc10", last_word); end
        checks++; if (last_changed !== 1'b1) begin errors++; $display("FAIL b2b_changed got=%b exp=1", last_changed); end
        // Repeat frame, with valid latency checked on the final digit
        send_digit(3, 4'hC);
        send_digit(2, 4'hC);
        send_digit(1, 4'h1);
        set_bus(4'b1110, glyph[0]);
        tick(6);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL latency_early got=%b exp=0", valid); end
        tick(1);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b exp=1", valid); end
        checks++; if (word !== 16'hCC10) begin errors++; $display("FAIL repeat_word got=%h exp=cc10", word); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL repeat_changed got=%b exp=0", changed); end
        tick(1);
        set_bus(4'hF, 7'h00);
        tick(2);
    endtask

    task automatic test_ghost();
        int v0, e0;
        send_digit(3, 4'h1);
        send_digit(2, 4'h2);
        v0 = nvalid;
        e0 = nerr;
        set_bus(4'b1100, glyph[5]);
        tick(10);
        set_bus(4'hF, 7'h00);
        tick(2);
        checks++; if (nerr !== e0) begin errors++; $display("FAIL ghost_seg_err got=%0d exp=%0d", nerr, e0); end
        checks++; if (nvalid !== v0) begin errors++; $display("FAIL ghost_valid got=%0d exp=%0d", nvalid, v0); end
        send_digit(1, 4'h3);
        checks++; if (nvalid !== v0) begin errors++; $display("FAIL ghost_partial got=%0d exp=%0d", nvalid, v0); end
        send_digit(0, 4'h4);
        checks++; if (nvalid !== v0 + 1) begin errors++; $display("FAIL ghost_complete got=%0d exp=%0d", nvalid, v0 + 1); end
        checks++; if (last_word !== 16'h1234) begin errors++; $display("FAIL ghost_word got=%h exp=1234", last_word); end
    endtask

    task automatic test_seg_err();
        int v0, e0;
        v0 = nvalid;
        e0 = nerr;
        send_digit(3, 4'h5);
        send_digit(1, 4'h7);
        send_digit(0, 4'h8);
        set_bus(4'b1011, 7'b0000000);
        tick(8);
        set_bus(4'hF, 7'h00);
        tick(2);
        checks++; if (nerr !== e0 + 1) begin errors++; $display("FAIL seg_err_count got=%0d exp=%0d", nerr, e0 + 1); end
        checks++; if (nvalid !== v0) begin errors++; $display("FAIL seg_err_valid got=%0d exp=%0d", nvalid, v0); end
        send_digit(2, 4'h6);
        checks++; if (nvalid !== v0 + 1) begin errors++; $display("FAIL seg_err_complete got=%0d exp=%0d", nvalid, v0 + 1); end
        checks++; if (last_word !== 16'h5678) begin errors++; $display("FAIL seg_err_word got=%h exp=5678", last_word); end
        checks++; if (nerr !== e0 + 1) begin errors++; $display("FAIL seg_err_once got=%0d exp=%0d", nerr, e0 + 1); end
    endtask

    task automatic test_timeout();
        int v0;
        send_digit(3, 4'h9);
        send_digit(2, 4'hE);
        tick(4000);
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_early got=%b exp=0", stale); end
        tick(100);
        checks++; if (stale !== 1'b1) begin errors++; $display("FAIL stale_set got=%b exp=1", stale); end
        v0 = nvalid;
        send_digit(1, 4'hB);
        send_digit(0, 4'hD);
        checks++; if (nvalid !== v0) begin errors++; $display("FAIL stale_mask_cleared got=%0d exp=%0d", nvalid, v0); end
        send_digit(3, 4'h9);
        send_digit(2, 4'hE);
        checks++; if (nvalid !== v0 + 1) begin errors++; $display("FAIL stale_recover got=%0d exp=%0d", nvalid, v0 + 1); end
        checks++; if (last_word !== 16'h9EBD) begin errors++; $display("FAIL stale_word got=%h exp=9ebd", last_word); end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_clear got=%b exp=0", stale); end
    endtask

    task automatic test_reset_midframe();
        int v0;
        send_digit(3, 4'hF);
        send_digit(2, 4'h0);
        send_digit(1, 4'h0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        checks++; if (word !== 16'h0000) begin errors++; $display("FAIL midreset_word got=%h exp=0000", word); end
        v0 = nvalid;
        send_digit(0, 4'hF);
        checks++; if (nvalid !== v0) begin errors++; $display("FAIL midreset_mask got=%0d exp=%0d", nvalid, v0); end
        send_word(16'hF00F);
        checks++; if (nvalid !== v0 + 1) begin errors++; $display("FAIL midreset_frame got=%0d exp=%0d", nvalid, v0 + 1); end
        checks++; if (last_word !== 16'hF00F) begin errors++; $display("FAIL midreset_word2 got=%h exp=f00f", last_word); end
        checks++; if (last_changed !== 1'b1) begin errors++; $display("FAIL midreset_changed got=%b exp=1", last_changed); end
    endtask

    initial begin
        glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000;
        glyph[2]  = 7'b1101101; glyph[3]  = 7'b1111001;
        glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011;
        glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000;
        glyph[8]  = 7'b1111111; glyph[9]  = 7'b1111011;
        glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
        glyph[12] = 7'b1001110; glyph[13] = 7'b0111101;
        glyph[14] = 7'b1001111; glyph[15] = 7'b1000111;
        reset = 1'b1;
        set_bus(4'hF, 7'h00);

        test_reset();
        test_frame();
        test_back_to_back();
        test_ghost();
        test_seg_err();
        test_timeout();
        test_reset_midframe();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
